// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, default DMEM depth.
package lsu_pkg;

  localparam int DMEM_WORDS_LOG2_DEF = 8;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_READ,
    WRITE,
    RESP
  } state_e;

endpackage

// File: rtl/lsu_if.sv
// Pipeline request/response handshake plus the DMEM pin bundle seen by the load/store unit.
interface lsu_if;

  logic        LSU_req_valid;
  logic        LSU_req_ready;
  logic        LSU_req_write;
  logic [1:0]  LSU_req_size;
  logic        LSU_req_signed;
  logic [31:0] LSU_req_addr;
  logic [31:0] LSU_req_wdata;
  logic        LSU_resp_valid;
  logic [31:0] LSU_resp_rdata;
  logic        LSU_resp_err;
  logic [31:0] DMEM_address;
  logic [31:0] DMEM_data_in;
  logic        DMEM_mem_write;
  logic        DMEM_mem_read;
  logic [31:0] DMEM_data_out;

  modport slave (
    input  LSU_req_valid, LSU_req_write, LSU_req_size, LSU_req_signed,
    input  LSU_req_addr, LSU_req_wdata, DMEM_data_out,
    output LSU_req_ready, LSU_resp_valid, LSU_resp_rdata, LSU_resp_err,
    output DMEM_address, DMEM_data_in, DMEM_mem_write, DMEM_mem_read
  );

  modport master (
    output LSU_req_valid, LSU_req_write, LSU_req_size, LSU_req_signed,
    output LSU_req_addr, LSU_req_wdata, DMEM_data_out,
    input  LSU_req_ready, LSU_resp_valid, LSU_resp_rdata, LSU_resp_err,
    input  DMEM_address, DMEM_data_in, DMEM_mem_write, DMEM_mem_read
  );

endinterface

// File: rtl/lsu_align.sv
// Little-endian lane handling: load extraction with sign/zero extension, and sub-word store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sgn_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ldata_o,
  output logic [31:0] mword_o
);

  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;
  logic signed [31:0] sext_b;
  logic signed [31:0] sext_h;

  assign lane_b = rword_i[{lane_i, 3'b000} +: 8];
  assign lane_h = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
  assign sext_b = lane_b;
  assign sext_h = lane_h;

  always_comb begin
    ldata_o = 32'd0;
    case (size_i)
      SIZE_BYTE: ldata_o = sgn_i ? sext_b : {24'd0, lane_b};
      SIZE_HALF: ldata_o = sgn_i ? sext_h : {16'd0, lane_h};
      SIZE_WORD: ldata_o = rword_i;
      default:   ldata_o = 32'd0;
    endcase
  end

  // Half lane ignores addr[0], which is how unaligned halves get aligned down.
  always_comb begin
    mword_o = rword_i;
    case (size_i)
      SIZE_BYTE: mword_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      SIZE_HALF: begin
        if (lane_i[1]) mword_o[31:16] = wdata_i[15:0];
        else           mword_o[15:0]  = wdata_i[15:0];
      end
      SIZE_WORD: mword_o = wdata_i;
      default:   mword_o = rword_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit between execute and DMEM; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning down.
module lsu
  import lsu_pkg::*;
#(
  parameter int DMEM_WORDS_LOG2 = DMEM_WORDS_LOG2_DEF
) (
  input logic   clk,
  input logic   SYS_reset_n,
  lsu_if.slave  bus
);

  state_e      state_q, state_d;
  logic        accept, range_err, size_err, misalign, req_err;
  logic [31:0] word_idx;

  logic        write_q, sgn_q;
  logic [1:0]  size_q, lane_q;
  logic [31:0] wdata_q;

  logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [31:0] dmem_addr_q, dmem_addr_d, dmem_din_q, dmem_din_d;
  logic        resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [31:0] ld_data, merged;

  assign accept    = (state_q == IDLE) && bus.LSU_req_valid;
  assign word_idx  = {{(32 - DMEM_WORDS_LOG2){1'b0}}, bus.LSU_req_addr[DMEM_WORDS_LOG2+1:2]};
  assign range_err = (bus.LSU_req_addr >> (DMEM_WORDS_LOG2 + 2)) != 32'd0;
  assign size_err  = (bus.LSU_req_size == SIZE_RSVD);
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign  = ((bus.LSU_req_size == SIZE_HALF) && bus.LSU_req_addr[0]) ||
                     ((bus.LSU_req_size == SIZE_WORD) && (bus.LSU_req_addr[1:0] != 2'b00));
`else
  assign misalign  = 1'b0;
`endif
  assign req_err   = range_err | size_err | misalign;

  // Request fields are only meaningful after acceptance, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= bus.LSU_req_write;
      size_q  <= bus.LSU_req_size;
      sgn_q   <= bus.LSU_req_signed;
      lane_q  <= bus.LSU_req_addr[1:0];
      wdata_q <= bus.LSU_req_wdata;
    end
  end

  lsu_align u_align (
    .size_i  (size_q),
    .sgn_i   (sgn_q),
    .lane_i  (lane_q),
    .rword_i (bus.DMEM_data_out),
    .wdata_i (wdata_q),
    .ldata_o (ld_data),
    .mword_o (merged)
  );

  always_ff @(posedge clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.LSU_req_valid) begin
          if (req_err)                          state_d = RESP;
          else if (!bus.LSU_req_write)          state_d = LOAD;
          else if (bus.LSU_req_size == SIZE_WORD) state_d = WRITE;
          else                                  state_d = RMW_READ;
        end
      end
      LOAD:     state_d = RESP;
      RMW_READ: state_d = WRITE;
      WRITE:    state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so every strobe comes straight off a flop.
  always_comb begin
    mem_read_d   = (state_d == LOAD) || (state_d == RMW_READ);
    mem_write_d  = (state_d == WRITE);
    resp_valid_d = (state_d == RESP);
    resp_err_d   = accept && req_err;
    resp_rdata_d = (state_q == LOAD) ? ld_data : 32'd0;
    dmem_addr_d  = dmem_addr_q;
    dmem_din_d   = dmem_din_q;
    if (accept && !req_err) begin
      dmem_addr_d = word_idx;
      if (bus.LSU_req_write && (bus.LSU_req_size == SIZE_WORD)) dmem_din_d = bus.LSU_req_wdata;
    end
    if (state_q == RMW_READ) dmem_din_d = merged;
  end

  always_ff @(posedge clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      dmem_addr_q  <= 32'd0;
      dmem_din_q   <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_din_q   <= dmem_din_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus.LSU_req_ready  = (state_q == IDLE);
  assign bus.LSU_resp_valid = resp_valid_q;
  assign bus.LSU_resp_err   = resp_err_q;
  assign bus.LSU_resp_rdata = resp_rdata_q;
  assign bus.DMEM_address   = dmem_addr_q;
  assign bus.DMEM_data_in   = dmem_din_q;
  assign bus.DMEM_mem_read  = mem_read_q;
  assign bus.DMEM_mem_write = mem_write_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: vector table of requests against a negedge-write DMEM model.
module tb_lsu;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic preload = 1'b1;
  always #5 clk = ~clk;

  lsu_if bus();

  lsu #(.DMEM_WORDS_LOG2(8)) dut (
    .clk         (clk),
    .SYS_reset_n (rst_n),
    .bus         (bus)
  );

  logic [31:0] mem [0:255];

  always @(negedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      mem[1]   <= 32'h11223344;
      mem[4]   <= 32'h8899AABB;
      mem[255] <= 32'h0BADF00D;
    end else if (bus.DMEM_mem_write) begin
      mem[bus.DMEM_address[7:0]] <= bus.DMEM_data_in;
    end
  end

  assign bus.DMEM_data_out = mem[bus.DMEM_address[7:0]];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_maddr;
    logic [31:0] exp_din;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string name, input logic wr, input logic [1:0] size, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                     input logic err, input int lat, input int rd, input int wn,
                     input logic [31:0] maddr, input logic [31:0] din);
    vec_t v;
    v.name = name; v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = rdata; v.exp_err = err; v.exp_lat = lat; v.exp_rd = rd; v.exp_wr = wn;
    v.exp_maddr = maddr; v.exp_din = din;
    tbl.push_back(v);
  endtask

  task automatic run_req(input vec_t v);
    int lat, nrd, nwr, guard;
    logic both, busy_rdy;
    logic [31:0] maddr_seen, din_seen;
    nrd = 0; nwr = 0; guard = 0; both = 1'b0;
    maddr_seen = 32'hFFFFFFFF; din_seen = 32'hFFFFFFFF;
    @(negedge clk);
    while (!bus.LSU_req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check({v.name, " ready"}, 32'(bus.LSU_req_ready), 32'd1);
    bus.LSU_req_valid  = 1'b1;
    bus.LSU_req_write  = v.wr;
    bus.LSU_req_size   = v.size;
    bus.LSU_req_signed = v.sgn;
    bus.LSU_req_addr   = v.addr;
    bus.LSU_req_wdata  = v.wdata;
    @(posedge clk);
    #1;
    bus.LSU_req_valid = 1'b0;
    busy_rdy = bus.LSU_req_ready;
    lat = 1;
    while (!bus.LSU_resp_valid && lat < 8) begin
      if (bus.DMEM_mem_read)  begin nrd++; maddr_seen = bus.DMEM_address; end
      if (bus.DMEM_mem_write) begin nwr++; maddr_seen = bus.DMEM_address; din_seen = bus.DMEM_data_in; end
      if (bus.DMEM_mem_read && bus.DMEM_mem_write) both = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    check({v.name, " busy_ready"}, 32'(busy_rdy), 32'd0);
    check({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
    check({v.name, " err"}, 32'(bus.LSU_resp_err), 32'(v.exp_err));
    check({v.name, " rdata"}, bus.LSU_resp_rdata, v.exp_rdata);
    check({v.name, " reads"}, 32'(nrd), 32'(v.exp_rd));
    check({v.name, " writes"}, 32'(nwr), 32'(v.exp_wr));
    check({v.name, " rd_and_wr"}, 32'(both), 32'd0);
    check({v.name, " resp_strobes"}, 32'({bus.DMEM_mem_read, bus.DMEM_mem_write}), 32'd0);
    if (v.exp_rd + v.exp_wr > 0) check({v.name, " dmem_addr"}, maddr_seen, v.exp_maddr);
    if (v.exp_wr > 0) check({v.name, " data_in"}, din_seen, v.exp_din);
    @(posedge clk);
    #1;
    check({v.name, " resp_pulse"}, 32'(bus.LSU_resp_valid), 32'd0);
  endtask

  initial begin
    bus.LSU_req_valid = 1'b0; bus.LSU_req_write = 1'b0; bus.LSU_req_size = 2'b00;
    bus.LSU_req_signed = 1'b0; bus.LSU_req_addr = 32'd0; bus.LSU_req_wdata = 32'd0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst ready", 32'(bus.LSU_req_ready), 32'd1);
    check("rst resp", 32'({bus.LSU_resp_valid, bus.LSU_resp_err}), 32'd0);
    check("rst rdata", bus.LSU_resp_rdata, 32'd0);
    check("rst strobes", 32'({bus.DMEM_mem_read, bus.DMEM_mem_write}), 32'd0);
    check("rst addr", bus.DMEM_address, 32'd0);
    check("rst din", bus.DMEM_data_in, 32'd0);
    preload = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    //   name          wr    size       sgn   addr        wdata         rdata         err lat rd wr maddr  din
    add("ldb_s_11",   1'b0, SIZE_BYTE, 1'b1, 32'h11,    32'h0,        32'hFFFFFFAA, 0,  2, 1, 0, 32'd4,  32'h0);
    add("ldb_u_11",   1'b0, SIZE_BYTE, 1'b0, 32'h11,    32'h0,        32'h000000AA, 0,  2, 1, 0, 32'd4,  32'h0);
    add("ldh_u_12",   1'b0, SIZE_HALF, 1'b0, 32'h12,    32'h0,        32'h00008899, 0,  2, 1, 0, 32'd4,  32'h0);
    add("ldh_s_12",   1'b0, SIZE_HALF, 1'b1, 32'h12,    32'h0,        32'hFFFF8899, 0,  2, 1, 0, 32'd4,  32'h0);
    add("ldw_10",     1'b0, SIZE_WORD, 1'b0, 32'h10,    32'h0,        32'h8899AABB, 0,  2, 1, 0, 32'd4,  32'h0);
    add("stb_13",     1'b1, SIZE_BYTE, 1'b0, 32'h13,    32'hFFFFFF5C, 32'h0,        0,  3, 1, 1, 32'd4,  32'h5C99AABB);
    add("ldw_10_rb",  1'b0, SIZE_WORD, 1'b0, 32'h10,    32'h0,        32'h5C99AABB, 0,  2, 1, 0, 32'd4,  32'h0);
    add("stw_08",     1'b1, SIZE_WORD, 1'b0, 32'h08,    32'hDEADBEEF, 32'h0,        0,  2, 0, 1, 32'd2,  32'hDEADBEEF);
    add("ldw_08",     1'b0, SIZE_WORD, 1'b0, 32'h08,    32'h0,        32'hDEADBEEF, 0,  2, 1, 0, 32'd2,  32'h0);
    add("sth_0a",     1'b1, SIZE_HALF, 1'b0, 32'h0A,    32'h1234ABCD, 32'h0,        0,  3, 1, 1, 32'd2,  32'hABCDBEEF);
    add("ldh_s_0a",   1'b0, SIZE_HALF, 1'b1, 32'h0A,    32'h0,        32'hFFFFABCD, 0,  2, 1, 0, 32'd2,  32'h0);
    add("ldb_s_08",   1'b0, SIZE_BYTE, 1'b1, 32'h08,    32'h0,        32'hFFFFFFEF, 0,  2, 1, 0, 32'd2,  32'h0);
    add("ldb_u_0b",   1'b0, SIZE_BYTE, 1'b0, 32'h0B,    32'h0,        32'h000000AB, 0,  2, 1, 0, 32'd2,  32'h0);
    add("ldw_3fc",    1'b0, SIZE_WORD, 1'b0, 32'h3FC,   32'h0,        32'h0BADF00D, 0,  2, 1, 0, 32'd255, 32'h0);
    add("ldw_400",    1'b0, SIZE_WORD, 1'b0, 32'h400,   32'h0,        32'h0,        1,  1, 0, 0, 32'd0,  32'h0);
    add("stw_400",    1'b1, SIZE_WORD, 1'b0, 32'h400,   32'h00000001, 32'h0,        1,  1, 0, 0, 32'd0,  32'h0);
    add("ld_size11",  1'b0, SIZE_RSVD, 1'b0, 32'h10,    32'h0,        32'h0,        1,  1, 0, 0, 32'd0,  32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    add("ldw_06",     1'b0, SIZE_WORD, 1'b0, 32'h06,    32'h0,        32'h0,        1,  1, 0, 0, 32'd0,  32'h0);
    add("ldh_u_13",   1'b0, SIZE_HALF, 1'b0, 32'h13,    32'h0,        32'h0,        1,  1, 0, 0, 32'd0,  32'h0);
`else
    add("ldw_06",     1'b0, SIZE_WORD, 1'b0, 32'h06,    32'h0,        32'h11223344, 0,  2, 1, 0, 32'd1,  32'h0);
    add("ldh_u_13",   1'b0, SIZE_HALF, 1'b0, 32'h13,    32'h0,        32'h00005C99, 0,  2, 1, 0, 32'd4,  32'h0);
`endif

    foreach (tbl[i]) run_req(tbl[i]);

    check("mem4 final", mem[4], 32'h5C99AABB);
    check("mem2 final", mem[2], 32'hABCDBEEF);

    // Reset asserted while a byte store sits in RMW_READ.
    @(negedge clk);
    bus.LSU_req_valid = 1'b1; bus.LSU_req_write = 1'b1; bus.LSU_req_size = SIZE_BYTE;
    bus.LSU_req_signed = 1'b0; bus.LSU_req_addr = 32'h10; bus.LSU_req_wdata = 32'h77;
    @(posedge clk);
    #1;
    bus.LSU_req_valid = 1'b0;
    check("mid rmw_read", 32'(bus.DMEM_mem_read), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid async strobes", 32'({bus.DMEM_mem_read, bus.DMEM_mem_write}), 32'd0);
    check("mid async resp", 32'(bus.LSU_resp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("mid held strobes", 32'({bus.DMEM_mem_read, bus.DMEM_mem_write}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid ready", 32'(bus.LSU_req_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("mid no resp", 32'(bus.LSU_resp_valid), 32'd0);
      check("mid no write", 32'(bus.DMEM_mem_write), 32'd0);
    end
    check("mid mem4", mem[4], 32'h5C99AABB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting between the execute stage and the data memory (DMEM). Accepts one byte/halfword/word load or store request from the pipeline through a valid/ready handshake and converts the byte address to DMEM's word index. It drives DMEM's address/data/strobe pins, performs read-modify-write for sub-word stores, and returns aligned, sign- or zero-extended load data with a one-cycle response pulse.

## Interface
- `DMEM_WORDS_LOG2`, default 8: log2 of DMEM depth in 32-bit words (256 words).
- `clk`  in  1  system clock; all state changes on posedge.
- `SYS_reset_n`  in  1  reset, asynchronous, active-low.
- `LSU_req_valid`  in  1  request present.
- `LSU_req_ready`  out  1  unit idle, request accepted when valid&ready at posedge.
- `LSU_req_write`  in  1  1 = store, 0 = load.
- `LSU_req_size`  in  2  00 byte, 01 half, 10 word; 11 reserved (treated as error).
- `LSU_req_signed`  in  1  loads only: 1 sign-extend, 0 zero-extend.
- `LSU_req_addr`  in  32  byte address.
- `LSU_req_wdata`  in  32  store data, right-justified.
- `LSU_resp_valid`  out  1  one-cycle response pulse.
- `LSU_resp_rdata`  out  32  extended load data (0 for stores/errors).
- `LSU_resp_err`  out  1  request was misaligned, out of range or size 11.
- `DMEM_address`  out  32  word index, zero-extended.
- `DMEM_data_in`  out  32  full word to write.
- `DMEM_mem_write`  out  1  write strobe; DMEM writes on negedge of `clk`.
- `DMEM_mem_read`  out  1  read enable; DMEM read path is combinational.
- `DMEM_data_out`  in  32  read word.

## Operation
- States: IDLE, LOAD, RMW_READ, WRITE, RESP. `LSU_req_ready` = (state == IDLE).
- On acceptance, latch write/size/signed/addr/wdata; word index = addr[DMEM_WORDS_LOG2+1:2].
- Error check at acceptance: addr[31:DMEM_WORDS_LOG2+2] != 0, size 11, or misalignment (see Configuration). Error -> RESP with err=1, no DMEM strobe.
- Load: IDLE->LOAD (mem_read=1) -> capture, extract lane, extend -> RESP.
- Word store: IDLE->WRITE (mem_write=1, data_in=wdata) -> RESP.
- Byte/half store: IDLE->RMW_READ (mem_read=1) -> capture word, merge wdata[7:0]/[15:0] into lane -> WRITE -> RESP.
- Little-endian: byte lane = addr[1:0], half lane = addr[1].
- RESP: resp_valid=1 for one cycle, then IDLE. No response backpressure.
- DMEM strobes are registered outputs, asserted only in their state; mem_read and mem_write never both 1.
- `DMEM_address`/`DMEM_data_in` hold their last value outside access states.

## Timing
- Reset values: state IDLE, all DMEM outputs 0, resp_valid 0, resp_rdata 0, resp_err 0.
- Latency from accepting edge to resp_valid cycle: error 1 cycle, load 2, word store 2, sub-word store 3.
- Next request accepted at the edge ending RESP cycle+1 (IDLE); throughput 1 request per 2–4 cycles.
- Load data sampled at the posedge ending the LOAD cycle; RMW read data sampled at the posedge ending RMW_READ.
- Reset mid-operation: strobes drop asynchronously, state to IDLE, pending response discarded; a write already committed at a prior negedge stands, none is issued afterward.
- `LSU_req_*` ignored outside IDLE.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: half with addr[0]=1 or word with addr[1:0]!=0 -> err=1, no access.
- Undefined: misaligned addresses are silently aligned down (low bits forced to 0 for the lane) and the access proceeds; err raised only for range/size.

## Structure
- Package `lsu_pkg`: size encodings (SIZE_BYTE/HALF/WORD), state enum, DMEM_WORDS_LOG2 default constant.
- Sub-module `lsu_align` (combinational): load lane extraction + extension, store lane merge.

## Test plan
- DMEM word 4 = 0x8899AABB; signed byte load addr 0x11 -> resp_rdata 0xFFFFFFAA, err 0, resp_valid 2 cycles after accept.
- Unsigned half load addr 0x12 -> 0x00008899; signed -> 0xFFFF8899; mem_read high exactly one cycle.
- Byte store 0x5C to addr 0x13 -> one mem_read cycle then one mem_write cycle, data_in 0x5C99AABB, word 4 reads back 0x5C99AABB, resp 3 cycles after accept.
- Word store 0xDEADBEEF to 0x08 then word load 0x08 -> 0xDEADBEEF; DMEM_address 2.
- Word load addr 0x06: with macro -> err 1, no strobe, resp 1 cycle; without -> reads word 1. Addr 0x400 -> err 1 either way.
- Assert SYS_reset_n low during RMW_READ -> strobes 0 immediately, no write, no resp_valid, req_ready 1 after release.
